instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of two, 2 to 64.
REQ-003 The block SHALL have port clk  input  1  system clock, positive edge active.
REQ-004 The block SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 The block SHALL have port ir_load  input  1  push request: write read_data into the tail entry.
REQ-006 The block SHALL have port read_data  input  WIDTH  instruction word from instruction memory.
REQ-007 The block SHALL have port ir_pop  input  1  pop request: retire the head entry.
REQ-008 The block SHALL have port flush  input  1  discard all entries (branch redirect).
REQ-009 The block SHALL have port instr  output  WIDTH  head entry, combinational from storage.
REQ-010 The block SHALL have port instr_valid  output  1  queue non-empty; instr is meaningful.
REQ-011 The block SHALL have port count  output  clog2(DEPTH)+1  number of valid entries.
REQ-012 The block SHALL have port full  output  1  count == DEPTH.
REQ-013 The block SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-014 Storage SHALL be a circular buffer of DEPTH x WIDTH with wr_ptr and rd_ptr of clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-015 A push SHALL be accepted on a posedge when ir_load=1, flush=0, and (full=0 or an accepted pop occurs in the same cycle).
REQ-016 An accepted push SHALL write read_data at wr_ptr and increment wr_ptr.
REQ-017 A pop SHALL be accepted on a posedge when ir_pop=1, flush=0 and count>0; it SHALL increment rd_ptr.
REQ-018 ir_pop with count==0 SHALL be ignored, even if a push is accepted in the same cycle; no bypass of read_data to instr.
REQ-019 count SHALL update per cycle: +1 push only, -1 pop only, unchanged for both or neither.
REQ-020 Push and pop together while full SHALL be accepted; count stays DEPTH; head advances; new word enters at old head slot.
REQ-021 ir_load=1 while full with no accepted pop and flush=0 SHALL drop the word, leave storage unchanged and set overflow on that edge.
REQ-022 flush=1 SHALL, on the posedge, zero wr_ptr, rd_ptr and count; it takes priority over same-cycle push and pop; overflow clears.
REQ-023 Storage contents need not be cleared by flush or reset.
REQ-024 instr SHALL equal entry[rd_ptr] when count>0, else all zeros (NOP); instr_valid SHALL equal (count>0).
REQ-025 Latency: a word pushed into an empty queue SHALL appear on instr with instr_valid=1 one cycle after the accepting edge.
REQ-026 full SHALL equal (count==DEPTH); outputs SHALL be glitch-free functions of registered state only.

Reset
REQ-027 rst=1 SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, overflow=0, independent of clk.
REQ-028 During reset: instr=0, instr_valid=0, full=0, count=0; push, pop and flush are ignored.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first accepted push after release becomes the head.

Verification
REQ-030 Reset, push A0000001, A0000002 on two edges -> after 1st edge instr=A0000001, valid=1, count=1; after 2nd count=2, instr unchanged.
REQ-031 DEPTH=4: push 1,2,3,4 -> full=1, count=4; push 5 with no pop -> overflow=1, count=4; pop four times -> instr 1,2,3,4 in order, then valid=0, instr=0.
REQ-032 Full, push 9 plus pop same edge -> count=4, instr=2, full=1; after 3 more pops instr=9 (wrap-around verified).
REQ-033 count=3, assert flush with ir_load=1 and ir_pop=1 -> next edge count=0, valid=0, overflow=0, pushed word not stored.
REQ-034 Empty, ir_load=1 and ir_pop=1 with read_data=0000ABCD -> count=1, instr=0000ABCD.
REQ-035 count=2, assert rst between clock edges -> count=0, instr_valid=0 immediately without a clock edge; deassert and push 7 -> instr=7.

Source files
------------

// File: rtl/instr_queue.sv
// Circular instruction queue between instruction fetch and decode.
// Head word is presented combinationally; count, pointers and overflow are registered.
module instr_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ir_load,
  input  logic [WIDTH-1:0]       read_data,
  input  logic                   ir_pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       instr,
  output logic                   instr_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;

  // A pop frees a slot in the same cycle, so a push while full is accepted alongside it.
  always_comb begin
    pop_ok  = ir_pop && !flush && (count != '0);
    push_ok = ir_load && !flush && (!full || pop_ok);
    drop    = ir_load && !flush && full && !pop_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is intentionally not cleared; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= read_data;
  end

  always_comb begin
    instr_valid = (count != '0);
    full        = (count == CNT_W'(DEPTH));
    instr       = instr_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed scoreboard bench for instr_queue (WIDTH=32, DEPTH=4).
module tb_instr_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ir_load;
  logic [WIDTH-1:0] read_data;
  logic             ir_pop;
  logic             flush;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic [2:0]       count;
  logic             full;
  logic             overflow;

  instr_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ir_load(ir_load), .read_data(read_data),
    .ir_pop(ir_pop), .flush(flush), .instr(instr), .instr_valid(instr_valid),
    .count(count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  cnt;
    logic        vld;
    logic [31:0] ins;
    logic        ful;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s.%s: actual %h required %h", name, field, act, req);
    end
  endtask

  // Monitor: outputs depend only on state updated at posedge, so sample at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "count", 32'(count), 32'(e.cnt));
      chk(e.name, "valid", 32'(instr_valid), 32'(e.vld));
      chk(e.name, "instr", instr, e.ins);
      chk(e.name, "full", 32'(full), 32'(e.ful));
      chk(e.name, "overflow", 32'(overflow), 32'(e.ovf));
    end
  end

  task automatic expect_state(input string name, input logic [2:0] c, input logic v,
                              input logic [31:0] i, input logic f, input logic o);
    exp_t e;
    e.name = name; e.cnt = c; e.vld = v; e.ins = i; e.ful = f; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs from a negedge; expectation describes state after the edge.
  task automatic step(input string name, input logic ld, input logic [31:0] d, input logic pp,
                      input logic fl, input logic [2:0] c, input logic v, input logic [31:0] i,
                      input logic f, input logic o);
    ir_load = ld; read_data = d; ir_pop = pp; flush = fl;
    @(posedge clk);
    expect_state(name, c, v, i, f, o);
    @(negedge clk);
    ir_load = 1'b0; ir_pop = 1'b0; flush = 1'b0; read_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ir_load = 1'b1; read_data = 32'hFFFF_FFFF; ir_pop = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    expect_state("reset", 3'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; ir_load = 1'b0; ir_pop = 1'b0; read_data = '0;

    // Basic push latency and head stability
    step("push_a1", 1, 32'hA000_0001, 0, 0, 3'd1, 1, 32'hA000_0001, 0, 0);
    step("push_a2", 1, 32'hA000_0002, 0, 0, 3'd2, 1, 32'hA000_0001, 0, 0);
    step("flush0",  0, 32'h0,         0, 1, 3'd0, 0, 32'h0,         0, 0);

    // Fill, overflow, drain in order
    step("fill1", 1, 32'd1, 0, 0, 3'd1, 1, 32'd1, 0, 0);
    step("fill2", 1, 32'd2, 0, 0, 3'd2, 1, 32'd1, 0, 0);
    step("fill3", 1, 32'd3, 0, 0, 3'd3, 1, 32'd1, 0, 0);
    step("fill4", 1, 32'd4, 0, 0, 3'd4, 1, 32'd1, 1, 0);
    step("ovf5",  1, 32'd5, 0, 0, 3'd4, 1, 32'd1, 1, 1);
    step("pop1",  0, 32'd0, 1, 0, 3'd3, 1, 32'd2, 0, 1);
    step("pop2",  0, 32'd0, 1, 0, 3'd2, 1, 32'd3, 0, 1);
    step("pop3",  0, 32'd0, 1, 0, 3'd1, 1, 32'd4, 0, 1);
    step("pop4",  0, 32'd0, 1, 0, 3'd0, 0, 32'd0, 0, 1);
    step("pop_empty", 0, 32'd0, 1, 0, 3'd0, 0, 32'd0, 0, 1);
    step("flush_ovf", 0, 32'd0, 0, 1, 3'd0, 0, 32'd0, 0, 0);

    // Push+pop while full, then wrap-around
    step("w1", 1, 32'd1, 0, 0, 3'd1, 1, 32'd1, 0, 0);
    step("w2", 1, 32'd2, 0, 0, 3'd2, 1, 32'd1, 0, 0);
    step("w3", 1, 32'd3, 0, 0, 3'd3, 1, 32'd1, 0, 0);
    step("w4", 1, 32'd4, 0, 0, 3'd4, 1, 32'd1, 1, 0);
    step("full_pushpop", 1, 32'd9, 1, 0, 3'd4, 1, 32'd2, 1, 0);
    step("wp1", 0, 32'd0, 1, 0, 3'd3, 1, 32'd3, 0, 0);
    step("wp2", 0, 32'd0, 1, 0, 3'd2, 1, 32'd4, 0, 0);
    step("wp3", 0, 32'd0, 1, 0, 3'd1, 1, 32'd9, 0, 0);
    step("wp4", 0, 32'd0, 1, 0, 3'd0, 0, 32'd0, 0, 0);

    // Flush priority over simultaneous push and pop
    step("f11", 1, 32'd11, 0, 0, 3'd1, 1, 32'd11, 0, 0);
    step("f12", 1, 32'd12, 0, 0, 3'd2, 1, 32'd11, 0, 0);
    step("f13", 1, 32'd13, 0, 0, 3'd3, 1, 32'd11, 0, 0);
    step("f14", 1, 32'd14, 0, 0, 3'd4, 1, 32'd11, 1, 0);
    step("f15_ovf", 1, 32'd15, 0, 0, 3'd4, 1, 32'd11, 1, 1);
    step("fpop", 0, 32'd0, 1, 0, 3'd3, 1, 32'd12, 0, 1);
    step("flush_all", 1, 32'hDEAD_BEEF, 1, 1, 3'd0, 0, 32'd0, 0, 0);
    step("post_flush", 0, 32'd0, 0, 0, 3'd0, 0, 32'd0, 0, 0);

    // Push and pop on empty queue: pop ignored, no bypass
    step("empty_pushpop", 1, 32'h0000_ABCD, 1, 0, 3'd1, 1, 32'h0000_ABCD, 0, 0);
    step("abcd_pop", 0, 32'd0, 1, 0, 3'd0, 0, 32'd0, 0, 0);

    // Asynchronous reset mid-operation
    step("r21", 1, 32'd21, 0, 0, 3'd1, 1, 32'd21, 0, 0);
    step("r22", 1, 32'd22, 0, 0, 3'd2, 1, 32'd21, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_state("async_rst", 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    step("in_rst_push", 1, 32'd99, 1, 0, 3'd0, 0, 32'd0, 0, 0);
    rst = 1'b0;
    step("after_rst7", 1, 32'd7, 0, 0, 3'd1, 1, 32'd7, 0, 0);

    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
